// File: rtl/ws2812_pkg.sv
// ws2812_pkg
//   Shared definitions for the WS2812 pixel path (pixel feeder and serializer):
//   - default system clock and frame period,
//   - colour byte-lane positions inside a host {R,G,B} word,
//   - pixel-feeder FSM state encoding,
//   - GRB packing and per-channel brightness scaling helpers.
package ws2812_pkg;

  localparam int DEF_CLK_FRE      = 50_000_000;
  localparam int DEF_FRAME_PERIOD = 833_333;   // 60 Hz at 50 MHz

  // Byte lanes of a host colour word {R[7:0],G[7:0],B[7:0]}
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_SCALE = 2'd2,
    ST_SEND  = 2'd3
  } feeder_state_e;

  // WS2812 expects green first on the wire, so bit 23 carries G[7].
  function automatic logic [23:0] grb_pack(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    return {g, r, b};
  endfunction

  // (c * (bri + 1)) >> 8 : bri = 255 is the identity, bri = 0 gives 0.
  // 255 * 256 = 65280 still fits the 16-bit product.
  function automatic logic [7:0] scale_chan(input logic [7:0] c,
                                            input logic [7:0] bri);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, bri} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws2812_dpram.sv
// ws2812_dpram
//   Single-bank simple dual-port RAM: one synchronous write port, one read
//   port with a registered output. Contents are not reset.
// Ports:
//   clk      system clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (sampled every cycle)
//   rd_data  registered read data, valid the cycle after rd_addr
module ws2812_dpram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ws2812_pixel_feeder.sv
// ws2812_pixel_feeder
//   Double-buffered pixel store feeding the WS2812 serializer. The host
//   writes RGB colours into the back bank and requests a swap with commit;
//   the swap is applied only at a frame start. Each frame streams LED_NUM
//   brightness-scaled GRB words over a valid/ready handshake.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en/addr/data host write into the back bank ({R,G,B})
//   commit          request a bank swap at the next frame start
//   brightness      global scale, sampled at frame start
//   pix_valid/ready/data/last  pixel stream ({G,R,B}, bit 23 first)
//   frame_busy      frame start until the last pixel is accepted
//   swap_pending    commit seen, swap not yet applied
//   frame_overrun   one-cycle pulse when a frame tick hits a busy frame
module ws2812_pixel_feeder #(
  parameter int LED_NUM      = 64,
  parameter int ADDR_W       = 6,
  parameter int FRAME_PERIOD = ws2812_pkg::DEF_FRAME_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              commit,
  input  logic [7:0]        brightness,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_data,
  output logic              pix_last,
  output logic              frame_busy,
  output logic              swap_pending,
  output logic              frame_overrun
);
  import ws2812_pkg::*;

  localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int CNT_W = $clog2(FRAME_PERIOD);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LED_NUM - 1);
  localparam logic [ADDR_W:0]   LED_LIMIT = (ADDR_W + 1)'(LED_NUM);
  localparam logic [CNT_W-1:0]  TICK_MAX  = CNT_W'(FRAME_PERIOD - 1);

  feeder_state_e    state_q, state_d;
  logic             front_sel_q, front_sel_d;
  logic             swap_pending_q, swap_pending_d;
  logic             frame_busy_q, frame_busy_d;
  logic             frame_overrun_q, frame_overrun_d;
  logic             pix_valid_q, pix_valid_d;
  logic             pix_last_q, pix_last_d;
  logic [23:0]      pix_data_q, pix_data_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [7:0]       bri_q, bri_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  logic             tick;
  logic             wr_ok;
  logic [1:0]       bank_we;
  logic [23:0]      bank_rd [2];
  logic [23:0]      front_rd;

  // Out-of-range writes are dropped; the host always targets the back bank.
  assign wr_ok      = wr_en && ({1'b0, wr_addr} < LED_LIMIT);
  assign bank_we[0] = wr_ok &&  front_sel_q;
  assign bank_we[1] = wr_ok && !front_sel_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    ws2812_dpram #(
      .DEPTH  (LED_NUM),
      .ADDR_W (IDX_W),
      .DATA_W (24)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we[gi]),
      .wr_addr (wr_addr[IDX_W-1:0]),
      .wr_data (wr_data),
      .rd_addr (addr_q),
      .rd_data (bank_rd[gi])
    );
  end

  // front_sel only moves in IDLE, so the mux is stable for a whole frame.
  assign front_rd = front_sel_q ? bank_rd[1] : bank_rd[0];
  assign tick     = (tick_cnt_q == TICK_MAX);

  always_comb begin
    state_d         = state_q;
    front_sel_d     = front_sel_q;
    swap_pending_d  = swap_pending_q;
    frame_busy_d    = frame_busy_q;
    pix_valid_d     = pix_valid_q;
    pix_last_d      = pix_last_q;
    pix_data_d      = pix_data_q;
    addr_d          = addr_q;
    bri_d           = bri_q;
    tick_cnt_d      = tick ? '0 : tick_cnt_q + 1'b1;
    frame_overrun_d = tick && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (swap_pending_q) begin
            front_sel_d    = ~front_sel_q;
            swap_pending_d = 1'b0;
          end
          bri_d        = brightness;
          addr_d       = '0;
          frame_busy_d = 1'b1;
          state_d      = ST_READ;
        end
      end
      ST_READ: begin
        // addr_q is already on the RAM read port; data arrives next cycle.
        state_d = ST_SCALE;
      end
      ST_SCALE: begin
        pix_data_d  = grb_pack(scale_chan(front_rd[R_LSB +: 8], bri_q),
                               scale_chan(front_rd[G_LSB +: 8], bri_q),
                               scale_chan(front_rd[B_LSB +: 8], bri_q));
        pix_valid_d = 1'b1;
        pix_last_d  = (addr_q == LAST_IDX);
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (pix_last_q) begin
            frame_busy_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the swap so a commit coinciding with it targets the next frame.
    if (commit) begin
      swap_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      front_sel_q     <= 1'b0;
      swap_pending_q  <= 1'b0;
      frame_busy_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
      pix_valid_q     <= 1'b0;
      pix_last_q      <= 1'b0;
      pix_data_q      <= '0;
      addr_q          <= '0;
      bri_q           <= '0;
      tick_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      front_sel_q     <= front_sel_d;
      swap_pending_q  <= swap_pending_d;
      frame_busy_q    <= frame_busy_d;
      frame_overrun_q <= frame_overrun_d;
      pix_valid_q     <= pix_valid_d;
      pix_last_q      <= pix_last_d;
      pix_data_q      <= pix_data_d;
      addr_q          <= addr_d;
      bri_q           <= bri_d;
      tick_cnt_q      <= tick_cnt_d;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign pix_last      = pix_last_q;
  assign pix_data      = pix_data_q;
  assign frame_busy    = frame_busy_q;
  assign swap_pending  = swap_pending_q;
  assign frame_overrun = frame_overrun_q;

endmodule
